// File: rtl/hog_frame_ctrl.sv
// Frame-level sequencer for the HOG pipeline: start/ready handshake, one frame of
// pixel metering, end-of-frame finish pulse, completion/timeout tracking and frame stats.
module hog_frame_ctrl #(
  parameter int unsigned     IMAGE_SIZE = 18495,
  parameter int unsigned     PIX_CNT_W  = 15,
  parameter int unsigned     TO_W       = 24,
  parameter logic [TO_W-1:0] TIMEOUT    = 24'd4000000
) (
  input  logic        aclk,
  input  logic        arest_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        done_sticky,
  output logic        err_timeout,
  output logic [15:0] frame_cnt,
  output logic [31:0] cycle_cnt,
  input  logic [7:0]  s_p,
  input  logic        s_p_valid,
  output logic        s_p_ready,
  input  logic        hog_ready,
  input  logic        histogram_done,
  input  logic        write_feature_done,
  output logic [7:0]  p,
  output logic        p_valid,
  output logic        finish
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_RDY = 3'd1;
  localparam logic [2:0] ST_STREAM   = 3'd2;
  localparam logic [2:0] ST_FLUSH    = 3'd3;
  localparam logic [2:0] ST_WRITE    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(IMAGE_SIZE);
  localparam logic [TO_W-1:0]      TO_LAST  = TIMEOUT - TO_W'(1);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [2:0]           state_q, state_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [31:0]          cyc_q, cyc_d;
  logic [7:0]           p_q, p_d;
  logic                 p_valid_q, p_valid_d;
  logic                 last_q, last_d;
  logic                 finish_q, finish_d;
  logic                 done_q, done_d;
  logic                 done_sticky_q, done_sticky_d;
  logic                 err_q, err_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [31:0]          cycle_cnt_q, cycle_cnt_d;

  logic beat_s, abort_s, accept_s, to_run_s, to_hit_s;

  // Next-state, counters and output-register inputs
  always_comb begin
    beat_s   = s_p_valid && (state_q == ST_STREAM);
    abort_s  = abort && (state_q != ST_IDLE);
    accept_s = start && !abort && (state_q == ST_IDLE);
    to_run_s = (state_q == ST_WAIT_RDY) || (state_q == ST_FLUSH) || (state_q == ST_WRITE);
    to_hit_s = to_run_s && (to_cnt_q == TO_LAST);

    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    cyc_d         = cyc_q;
    p_d           = p_q;
    p_valid_d     = beat_s;
    done_d        = 1'b0;
    done_sticky_d = done_sticky_q;
    err_d         = err_q;
    frame_cnt_d   = frame_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;

    // Abort overrides every other transition, including a same-cycle start.
    if (abort_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) state_d = ST_WAIT_RDY;
          else          state_d = ST_IDLE;
        end
        ST_WAIT_RDY: begin
          if (hog_ready) begin
            state_d = ST_STREAM;
          end else if (to_hit_s) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WAIT_RDY;
          end
        end
        ST_STREAM: begin
          if (beat_s && (pix_cnt_q == LAST_PIX)) state_d = ST_FLUSH;
          else                                   state_d = ST_STREAM;
        end
        ST_FLUSH: begin
          if (histogram_done) begin
            state_d = ST_WRITE;
          end else if (to_hit_s) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        ST_WRITE: begin
          if (write_feature_done) begin
            state_d = ST_DONE;
          end else if (to_hit_s) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WRITE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if ((state_d != state_q) || !to_run_s) to_cnt_d = '0;
    else                                   to_cnt_d = to_cnt_q + TO_W'(1);

    // The frame's cycle count starts at 1 in the WAIT_RDY cycle following start.
    if (accept_s) begin
      pix_cnt_d     = '0;
      cyc_d         = 32'd1;
      done_sticky_d = 1'b0;
      err_d         = 1'b0;
    end else if (state_q != ST_IDLE) begin
      cyc_d = sat_inc32(cyc_q);
    end else begin
      cyc_d = cyc_q;
    end

    if (beat_s) begin
      pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
      p_d       = s_p;
    end else begin
      p_d       = p_q;
    end

    last_d   = beat_s && (pix_cnt_q == LAST_PIX) && !abort_s;
    finish_d = last_q && !abort_s;

    if ((state_q == ST_WRITE) && (state_d == ST_DONE)) begin
      done_d        = 1'b1;
      done_sticky_d = 1'b1;
      frame_cnt_d   = frame_cnt_q + 16'd1;
      cycle_cnt_d   = sat_inc32(cyc_q);
    end else begin
      frame_cnt_d   = frame_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      state_q       <= ST_IDLE;
      pix_cnt_q     <= '0;
      to_cnt_q      <= '0;
      cyc_q         <= 32'd0;
      p_q           <= 8'd0;
      p_valid_q     <= 1'b0;
      last_q        <= 1'b0;
      finish_q      <= 1'b0;
      done_q        <= 1'b0;
      done_sticky_q <= 1'b0;
      err_q         <= 1'b0;
      frame_cnt_q   <= 16'd0;
      cycle_cnt_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      to_cnt_q      <= to_cnt_d;
      cyc_q         <= cyc_d;
      p_q           <= p_d;
      p_valid_q     <= p_valid_d;
      last_q        <= last_d;
      finish_q      <= finish_d;
      done_q        <= done_d;
      done_sticky_q <= done_sticky_d;
      err_q         <= err_d;
      frame_cnt_q   <= frame_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign s_p_ready   = (state_q == ST_STREAM);
  assign done        = done_q;
  assign done_sticky = done_sticky_q;
  assign err_timeout = err_q;
  assign frame_cnt   = frame_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign p           = p_q;
  assign p_valid     = p_valid_q;
  assign finish      = finish_q;

endmodule

// File: tb/tb_hog_frame_ctrl.sv
// Directed bench for hog_frame_ctrl; a second instance with a short timeout
// shares the stimulus and is only inspected during the timeout scenario.
module tb_hog_frame_ctrl;
  localparam int NPIX = 18496;

  logic aclk = 1'b0, arest_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic s_p_valid = 1'b0, hog_ready = 1'b0, histogram_done = 1'b0, write_feature_done = 1'b0;
  logic [7:0] s_p = 8'd0;

  logic busy, done, done_sticky, err_timeout, s_p_ready, p_valid, finish;
  logic [15:0] frame_cnt;
  logic [31:0] cycle_cnt;
  logic [7:0] p;

  logic busy_to, done_to, done_sticky_to, err_to, s_p_ready_to, p_valid_to, finish_to;
  logic [15:0] frame_cnt_to;
  logic [31:0] cycle_cnt_to;
  logic [7:0] p_to;

  int checks = 0, failures = 0;
  int src_idx = 0;
  bit sent = 1'b0;

  int cyc = 0, pv_cnt = 0, pix_bad = 0, fin_cnt = 0, fin_cyc = 0, fin_at_pv = 0;
  int last_pv_cyc = 0, done_cnt = 0, done_to_cnt = 0;

  hog_frame_ctrl dut (
    .aclk(aclk), .arest_n(arest_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .done_sticky(done_sticky), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt), .cycle_cnt(cycle_cnt),
    .s_p(s_p), .s_p_valid(s_p_valid), .s_p_ready(s_p_ready),
    .hog_ready(hog_ready), .histogram_done(histogram_done), .write_feature_done(write_feature_done),
    .p(p), .p_valid(p_valid), .finish(finish)
  );

  hog_frame_ctrl #(.TIMEOUT(24'd64)) dut_to (
    .aclk(aclk), .arest_n(arest_n), .start(start), .abort(abort),
    .busy(busy_to), .done(done_to), .done_sticky(done_sticky_to), .err_timeout(err_to),
    .frame_cnt(frame_cnt_to), .cycle_cnt(cycle_cnt_to),
    .s_p(s_p), .s_p_valid(s_p_valid), .s_p_ready(s_p_ready_to),
    .hog_ready(hog_ready), .histogram_done(histogram_done), .write_feature_done(write_feature_done),
    .p(p_to), .p_valid(p_valid_to), .finish(finish_to)
  );

  always #5 aclk = ~aclk;

  function automatic logic [7:0] pix_val(input int k);
    logic [31:0] v;
    v = k * 37 + 11;
    return v[7:0];
  endfunction

  // Observation of the main instance's outputs, sampled mid-cycle
  always @(negedge aclk) begin
    cyc++;
    if (p_valid) begin
      if (p !== pix_val(pv_cnt)) pix_bad++;
      pv_cnt++;
      last_pv_cyc = cyc;
    end
    if (finish) begin
      fin_cnt++;
      fin_cyc   = cyc;
      fin_at_pv = pv_cnt;
    end
    if (done) done_cnt++;
    if (done_to) done_to_cnt++;
  end

  // Pixel source: n beats, valid with pct% probability after 'lead' ready cycles.
  task automatic stream(input int n, input int pct, input int lead, input bit do_abort, output int got);
    int rdy_seen;
    rdy_seen = 0;
    got = 0;
    sent = 1'b0;
    for (int c = 0; c < 100000 && got < n; c++) begin
      @(negedge aclk);
      if (sent) begin
        src_idx++;
        got++;
      end
      start = 1'b0;
      abort = 1'b0;
      if (got < n && rdy_seen >= lead) begin
        s_p       = pix_val(src_idx);
        s_p_valid = (pct >= 100) || ($urandom_range(99) < pct);
        if (do_abort && got == n - 1 && s_p_valid && s_p_ready) begin
          abort = 1'b1;
          start = 1'b1;
        end
      end else begin
        s_p_valid = 1'b0;
      end
      if (s_p_ready) rdy_seen++;
      sent = s_p_valid && s_p_ready;
    end
  endtask

  // From the cycle of the last p_valid: wait for finish, then pulse the two done strobes.
  task automatic finish_frame(input int hd, input int wd, input bit start_mid);
    for (int c = 0; c < 64 && finish !== 1'b1; c++) @(negedge aclk);
    if (start_mid) begin
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      repeat (hd - 1) @(negedge aclk);
    end else begin
      repeat (hd) @(negedge aclk);
    end
    histogram_done = 1'b1;
    @(negedge aclk);
    histogram_done = 1'b0;
    repeat (wd - 1) @(negedge aclk);
    write_feature_done = 1'b1;
    @(negedge aclk);
    write_feature_done = 1'b0;
  endtask

  task automatic test_reset();
    arest_n = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({busy, done, done_sticky, err_timeout, s_p_ready, p_valid, finish} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000000", {busy, done, done_sticky, err_timeout, s_p_ready, p_valid, finish});
    end
    checks++;
    if (frame_cnt !== 16'd0 || cycle_cnt !== 32'd0 || p !== 8'd0) begin
      failures++;
      $display("FAIL reset_counts frame_cnt=%0d cycle_cnt=%0d p=%0d want all 0", frame_cnt, cycle_cnt, p);
    end
    arest_n = 1'b1;
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_normal_frame();
    int got, pv0, fin0, done0;
    hog_ready = 1'b1;
    pv0 = pv_cnt; fin0 = fin_cnt; done0 = done_cnt;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    // Source comes up 3 cycles after ready opens; then 18496 back-to-back beats.
    stream(NPIX, 100, 3, 1'b0, got);
    finish_frame(10, 20, 1'b1);
    checks++;
    if (done !== 1'b1 || done_sticky !== 1'b1) begin
      failures++;
      $display("FAIL normal_done done=%b sticky=%b want 1 1", done, done_sticky);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL normal_frame_cnt got=%0d want=1", frame_cnt);
    end
    checks++;
    if (cycle_cnt !== 32'd18533) begin
      failures++;
      $display("FAIL normal_cycle_cnt got=%0d want=18533", cycle_cnt);
    end
    @(negedge aclk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_sticky !== 1'b1) begin
      failures++;
      $display("FAIL normal_after_done done=%b busy=%b sticky=%b want 0 0 1", done, busy, done_sticky);
    end
    repeat (2) @(negedge aclk);
    checks++;
    if (got !== NPIX || (pv_cnt - pv0) !== NPIX || pix_bad !== 0) begin
      failures++;
      $display("FAIL normal_pixels sent=%0d p_valid=%0d bad=%0d want %0d %0d 0", got, pv_cnt - pv0, pix_bad, NPIX, NPIX);
    end
    checks++;
    if ((fin_cnt - fin0) !== 1 || fin_cyc !== last_pv_cyc + 1) begin
      failures++;
      $display("FAIL normal_finish count=%0d at=%0d last_pv=%0d want 1 at last_pv+1", fin_cnt - fin0, fin_cyc, last_pv_cyc);
    end
    checks++;
    if ((done_cnt - done0) !== 1) begin
      failures++;
      $display("FAIL normal_done_count got=%0d want=1", done_cnt - done0);
    end
  endtask

  task automatic test_ready_gating_abort();
    int got, bad, fin0, done0;
    hog_ready = 1'b0;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (s_p_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge aclk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL gating_ready_low bad_cycles=%0d want=0", bad);
    end
    hog_ready = 1'b1;
    @(negedge aclk);
    checks++;
    if (s_p_ready !== 1'b1) begin
      failures++;
      $display("FAIL gating_ready_rise got=%b want=1", s_p_ready);
    end
    fin0 = fin_cnt; done0 = done_cnt;
    stream(5000, 100, 0, 1'b1, got);
    checks++;
    if (s_p_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_state ready=%b busy=%b want 0 0", s_p_ready, busy);
    end
    checks++;
    if (p_valid !== 1'b1 || p !== pix_val(src_idx - 1)) begin
      failures++;
      $display("FAIL abort_last_beat p_valid=%b p=%0d want 1 %0d", p_valid, p, pix_val(src_idx - 1));
    end
    repeat (3) @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL abort_start_dropped busy=%b frame_cnt=%0d want 0 1", busy, frame_cnt);
    end
    checks++;
    if ((fin_cnt - fin0) !== 0 || (done_cnt - done0) !== 0 || got !== 5000) begin
      failures++;
      $display("FAIL abort_no_finish finish=%0d done=%0d sent=%0d want 0 0 5000", fin_cnt - fin0, done_cnt - done0, got);
    end
  endtask

  task automatic test_clean_frame();
    int got, pv0, fin0;
    pv0 = pv_cnt; fin0 = fin_cnt;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    stream(NPIX, 100, 0, 1'b0, got);
    finish_frame(10, 20, 1'b0);
    checks++;
    if (done !== 1'b1 || frame_cnt !== 16'd2 || cycle_cnt !== 32'd18530) begin
      failures++;
      $display("FAIL clean_done done=%b frame_cnt=%0d cycle_cnt=%0d want 1 2 18530", done, frame_cnt, cycle_cnt);
    end
    repeat (2) @(negedge aclk);
    checks++;
    if ((pv_cnt - pv0) !== NPIX || pix_bad !== 0 || (fin_cnt - fin0) !== 1) begin
      failures++;
      $display("FAIL clean_stream p_valid=%0d bad=%0d finish=%0d want %0d 0 1", pv_cnt - pv0, pix_bad, fin_cnt - fin0, NPIX);
    end
  endtask

  task automatic test_backpressure_timeout_reset();
    int got, pv0, fin0, dto0;
    pv0 = pv_cnt; fin0 = fin_cnt; dto0 = done_to_cnt;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    stream(NPIX, 50, 0, 1'b0, got);
    for (int c = 0; c < 64 && finish !== 1'b1; c++) @(negedge aclk);
    // histogram_done withheld: the short-timeout instance expires on its 64th FLUSH cycle.
    repeat (62) @(negedge aclk);
    checks++;
    if (busy_to !== 1'b1 || err_to !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early busy=%b err=%b want 1 0", busy_to, err_to);
    end
    @(negedge aclk);
    checks++;
    if (err_to !== 1'b1 || busy_to !== 1'b0 || frame_cnt_to !== 16'd2 || (done_to_cnt - dto0) !== 0) begin
      failures++;
      $display("FAIL timeout_hit err=%b busy=%b frame_cnt=%0d done=%0d want 1 0 2 0", err_to, busy_to, frame_cnt_to, done_to_cnt - dto0);
    end
    checks++;
    if (got !== NPIX || (pv_cnt - pv0) !== NPIX || pix_bad !== 0) begin
      failures++;
      $display("FAIL bp_pixels sent=%0d p_valid=%0d bad=%0d want %0d %0d 0", got, pv_cnt - pv0, pix_bad, NPIX, NPIX);
    end
    checks++;
    if ((fin_cnt - fin0) !== 1 || (fin_at_pv - pv0) !== NPIX || fin_cyc !== last_pv_cyc + 1) begin
      failures++;
      $display("FAIL bp_finish count=%0d after_beats=%0d at=%0d last_pv=%0d want 1 %0d last_pv+1", fin_cnt - fin0, fin_at_pv - pv0, fin_cyc, last_pv_cyc, NPIX);
    end
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    checks++;
    if (err_to !== 1'b0 || busy_to !== 1'b1) begin
      failures++;
      $display("FAIL timeout_clear err=%b busy=%b want 0 1", err_to, busy_to);
    end
    checks++;
    if (busy !== 1'b1 || frame_cnt !== 16'd2) begin
      failures++;
      $display("FAIL start_while_busy busy=%b frame_cnt=%0d want 1 2", busy, frame_cnt);
    end
    histogram_done = 1'b1;
    @(negedge aclk);
    histogram_done = 1'b0;
    arest_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, done_sticky, err_timeout, s_p_ready, p_valid, finish} !== 7'b0 ||
        frame_cnt !== 16'd0 || cycle_cnt !== 32'd0 || p !== 8'd0) begin
      failures++;
      $display("FAIL async_reset flags=%b frame_cnt=%0d cycle_cnt=%0d p=%0d want all 0",
               {busy, done, done_sticky, err_timeout, s_p_ready, p_valid, finish}, frame_cnt, cycle_cnt, p);
    end
    @(negedge aclk);
    arest_n = 1'b1;
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_idle busy=%b frame_cnt=%0d want 0 0", busy, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_ready_gating_abort();
    test_clean_frame();
    test_backpressure_timeout_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
